// File: rtl/reg_bank_pkg.sv
// Shared constants, types and small helpers for the multi-port register bank.
package reg_bank_pkg;

    localparam int REG_AW    = 5;
    localparam int NREG      = 32;
    // Widest port count the helpers below accept; NWR and NRS must not exceed it.
    localparam int MAX_PORTS = 8;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // A write port after the x0 filter: valid only when enabled and not aimed at x0.
    typedef struct packed {
        logic      vld;
        reg_addr_t add;
    } wr_req_t;

    // Index of the highest set bit, or -1 when none is set.
    // The highest port index always wins an address conflict.
    function automatic int prio_idx(input logic [MAX_PORTS-1:0] hits);
        int idx;
        idx = -1;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (hits[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // Address of port i out of a flat, zero-extended port address bus.
    function automatic reg_addr_t add_slice(input logic [MAX_PORTS*REG_AW-1:0] v, input int i);
        return v[REG_AW*i +: REG_AW];
    endfunction

endpackage

// File: rtl/reg_bank_mp_if.sv
// Decode/writeback side bus of the register bank.
interface reg_bank_mp_if #(
    parameter int NWR   = 2,
    parameter int NRS   = 2,
    parameter int XLEN  = 32,
    parameter int TAG_W = 2
);
    logic                  clear_de;
    logic [NWR-1:0]        wr_en;
    logic [NWR*5-1:0]      wr_add;
    logic [NWR*XLEN-1:0]   wr_data;
    logic [NRS-1:0]        rs_en;
    logic [NRS*5-1:0]      rs_add;
    logic                  rd_en;
    logic [4:0]            rd_add;
    logic [NRS*XLEN-1:0]   rs_data;
    logic [NRS-1:0]        rs_wait;
    logic [NRS*TAG_W-1:0]  rs_tag;
    logic                  rd_wait;
    logic [TAG_W-1:0]      rd_tag;

    modport master (
        output clear_de, wr_en, wr_add, wr_data, rs_en, rs_add, rd_en, rd_add,
        input  rs_data, rs_wait, rs_tag, rd_wait, rd_tag
    );

    modport slave (
        input  clear_de, wr_en, wr_add, wr_data, rs_en, rs_add, rd_en, rd_add,
        output rs_data, rs_wait, rs_tag, rd_wait, rd_tag
    );
endinterface

// File: rtl/reg_pend_ctr.sv
// Saturating pending-write counter for one register.
// Releases never take it below zero; a clear beats any same-cycle increment or release.
module reg_pend_ctr #(
    parameter int CNT_W = 3,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec_n,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);
    localparam int SW = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SW-1:0]    cur;
    logic [SW-1:0]    rel;
    logic [SW-1:0]    sum;

    // Next count: add the issue, remove at most the current count of releases, then saturate.
    always_comb begin
        cur = SW'(cnt_q);
        rel = (SW'(dec_n) < cur) ? SW'(dec_n) : cur;
        sum = cur + SW'(inc) - rel;
        if (clr) begin
            cnt_d = '0;
        end else if (sum > CNT_MAX) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = &cnt_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank with write-pending scoreboard and per-register rename tags.
// Reads are combinational with same-cycle writeback bypass; x0 is hard-wired to zero.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int              NWR     = 2,
    parameter int              NRS     = 2,
    parameter int              XLEN    = 32,
    parameter int              CNT_W   = 3,
    parameter int              TAG_W   = 2,
    parameter int              WAW_OK  = 0,
    parameter int              SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = 32'h0002f000
) (
    input logic          clk,
    input logic          reset,
    reg_bank_mp_if.slave bus
);
    localparam int NW_W = $clog2(NWR + 1);
    localparam int CW   = (CNT_W > NW_W) ? CNT_W : NW_W;

    wr_req_t                wr_req [NWR];
    logic [XLEN-1:0]        wr_data_a [NWR];
    logic [MAX_PORTS-1:0]   w_hit [NREG];
    int                     w_sel [NREG];
    logic [NW_W-1:0]        nw [NREG];

    logic [XLEN-1:0]        mem_q [NREG];
    logic [XLEN-1:0]        mem_d [NREG];
    logic [TAG_W-1:0]       tag_q [NREG];
    logic [TAG_W-1:0]       tag_d [NREG];
    logic [CNT_W-1:0]       cnt [NREG];
    logic [NREG-1:0]        sat;
    logic [NREG-1:0]        inc;

    reg_addr_t              rs_add_a [NRS];
    logic [XLEN-1:0]        rs_data_a [NRS];
    logic                   vrd;
    logic                   rd_wait;
    logic                   iss;

    // Qualify write ports: x0 writes are dropped before they reach arbitration or release.
    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            wr_req[i].add = add_slice((MAX_PORTS*REG_AW)'(bus.wr_add), i);
            wr_req[i].vld = bus.wr_en[i] && (wr_req[i].add != '0);
            wr_data_a[i]  = bus.wr_data[XLEN*i +: XLEN];
        end
    end

    // Per-register write hits: winning port for mem/bypass and release count for the scoreboard.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_hit[r] = '0;
            nw[r]    = '0;
            for (int i = 0; i < NWR; i++) begin
                w_hit[r][i] = wr_req[i].vld && (wr_req[i].add == REG_AW'(r));
                if (w_hit[r][i]) begin
                    nw[r] = nw[r] + 1'b1;
                end
            end
            w_sel[r] = prio_idx(w_hit[r]);
        end
    end

    // Next register contents: the highest-index hitting port lands.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            mem_d[r] = mem_q[r];
            for (int i = 0; i < NWR; i++) begin
                if (i == w_sel[r]) begin
                    mem_d[r] = wr_data_a[i];
                end
            end
        end
    end

    // Source ports: bypassed data, tag of the current producer, and operand-not-ready.
    // rs_wait compares against this cycle's releases so a landing write clears it at once.
    always_comb begin
        for (int j = 0; j < NRS; j++) begin
            rs_add_a[j]  = bus.rs_add[REG_AW*j +: REG_AW];
            rs_data_a[j] = mem_q[rs_add_a[j]];
            for (int i = 0; i < NWR; i++) begin
                if (i == w_sel[rs_add_a[j]]) begin
                    rs_data_a[j] = wr_data_a[i];
                end
            end
            bus.rs_wait[j] = bus.rs_en[j] && (rs_add_a[j] != '0) &&
                             (CW'(cnt[rs_add_a[j]]) > CW'(nw[rs_add_a[j]]));
            bus.rs_tag[TAG_W*j +: TAG_W] = tag_q[rs_add_a[j]];
        end
    end

    for (genvar j = 0; j < NRS; j++) begin : g_rs_out
        assign bus.rs_data[XLEN*j +: XLEN] = rs_data_a[j];
    end

    // Destination issue: strict mode blocks on any outstanding write, permissive mode
    // only when the counter is full and nothing is draining it this cycle.
    always_comb begin
        vrd = bus.rd_en && (bus.rd_add != '0);
        if (WAW_OK != 0) begin
            rd_wait = vrd && sat[bus.rd_add] && (nw[bus.rd_add] == '0);
        end else begin
            rd_wait = vrd && (CW'(cnt[bus.rd_add]) > CW'(nw[bus.rd_add]));
        end
        iss = vrd && !rd_wait;
        for (int r = 0; r < NREG; r++) begin
            inc[r]   = iss && (bus.rd_add == REG_AW'(r));
            tag_d[r] = tag_q[r] + TAG_W'(inc[r]);
        end
    end

    assign bus.rd_wait = rd_wait;
    assign bus.rd_tag  = tag_q[bus.rd_add];

    for (genvar r = 0; r < NREG; r++) begin : g_pend
        reg_pend_ctr #(
            .CNT_W (CNT_W),
            .DEC_W (NW_W)
        ) u_ctr (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[r]),
            .dec_n (nw[r]),
            .clr   (bus.clear_de),
            .cnt   (cnt[r]),
            .sat   (sat[r])
        );
    end

    // Register file and rename tags; only the stack pointer has a non-zero reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
                tag_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= mem_d[r];
                tag_q[r] <= tag_d[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed scoreboard bench for reg_bank_mp: a strict (WAW_OK=0) and a permissive (WAW_OK=1)
// bank share one stimulus stream; expectations are queued per vector and checked at negedge.
module tb_reg_bank_mp;

    localparam logic [31:0] SP_INIT = 32'h0002f000;
    localparam int D_STRICT = 0;
    localparam int D_PERM   = 1;
    localparam int S_RS_DATA = 0;
    localparam int S_RS_WAIT = 1;
    localparam int S_RS_TAG  = 2;
    localparam int S_RD_WAIT = 3;
    localparam int S_RD_TAG  = 4;

    logic clk;
    logic reset;

    reg_bank_mp_if #(.NWR(2), .NRS(2), .XLEN(32), .TAG_W(2)) bus_s ();
    reg_bank_mp_if #(.NWR(2), .NRS(2), .XLEN(32), .TAG_W(2)) bus_p ();

    reg_bank_mp #(
        .NWR(2), .NRS(2), .XLEN(32), .CNT_W(3), .TAG_W(2),
        .WAW_OK(0), .SP_IDX(2), .SP_INIT(SP_INIT)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    reg_bank_mp #(
        .NWR(2), .NRS(2), .XLEN(32), .CNT_W(3), .TAG_W(2),
        .WAW_OK(1), .SP_IDX(2), .SP_INIT(SP_INIT)
    ) dut_p (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_p.slave)
    );

    assign bus_s.clear_de = bus_p.clear_de;
    assign bus_s.wr_en    = bus_p.wr_en;
    assign bus_s.wr_add   = bus_p.wr_add;
    assign bus_s.wr_data  = bus_p.wr_data;
    assign bus_s.rs_en    = bus_p.rs_en;
    assign bus_s.rs_add   = bus_p.rs_add;
    assign bus_s.rd_en    = bus_p.rd_en;
    assign bus_s.rd_add   = bus_p.rd_add;

    typedef struct packed {
        int          dut;
        int          sel;
        int          idx;
        int          vec;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   vec_no;
    logic done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string sel_name(input int sel);
        case (sel)
            S_RS_DATA: return "rs_data";
            S_RS_WAIT: return "rs_wait";
            S_RS_TAG:  return "rs_tag";
            S_RD_WAIT: return "rd_wait";
            default:   return "rd_tag";
        endcase
    endfunction

    function automatic logic [31:0] actual(input exp_t e);
        logic [63:0] d;
        logic [1:0]  w;
        logic [3:0]  t;
        logic        rw;
        logic [1:0]  rt;
        if (e.dut == D_STRICT) begin
            d = bus_s.rs_data; w = bus_s.rs_wait; t = bus_s.rs_tag;
            rw = bus_s.rd_wait; rt = bus_s.rd_tag;
        end else begin
            d = bus_p.rs_data; w = bus_p.rs_wait; t = bus_p.rs_tag;
            rw = bus_p.rd_wait; rt = bus_p.rd_tag;
        end
        case (e.sel)
            S_RS_DATA: return (e.idx == 0) ? d[31:0] : d[63:32];
            S_RS_WAIT: return {31'b0, (e.idx == 0) ? w[0] : w[1]};
            S_RS_TAG:  return {30'b0, (e.idx == 0) ? t[1:0] : t[3:2]};
            S_RD_WAIT: return {31'b0, rw};
            default:   return {30'b0, rt};
        endcase
    endfunction

    // Monitor: outputs are combinational, so every queued expectation is due at this negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = actual(e);
            total++;
            if (act !== e.val) begin
                bad++;
                $display("FAIL v%0d %s.%s%0d: got %h want %h",
                         e.vec, (e.dut == D_STRICT) ? "strict" : "perm",
                         sel_name(e.sel), e.idx, act, e.val);
            end
        end
    end

    task automatic want(input int dut, input int sel, input int idx, input logic [31:0] val);
        exp_t e;
        e.dut = dut; e.sel = sel; e.idx = idx; e.vec = vec_no; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic want2(input int sel, input int idx, input logic [31:0] val);
        want(D_STRICT, sel, idx, val);
        want(D_PERM, sel, idx, val);
    endtask

    task automatic idle();
        bus_p.clear_de = 1'b0;
        bus_p.wr_en    = '0;
        bus_p.wr_add   = '0;
        bus_p.wr_data  = '0;
        bus_p.rs_en    = '0;
        bus_p.rs_add   = '0;
        bus_p.rd_en    = 1'b0;
        bus_p.rd_add   = '0;
    endtask

    // Start a new vector: the previous one is committed on this edge.
    task automatic vec();
        @(posedge clk);
        #1;
        idle();
        vec_no++;
    endtask

    task automatic wr(input int port, input logic [4:0] add, input logic [31:0] data);
        if (port == 0) begin
            bus_p.wr_en[0] = 1'b1; bus_p.wr_add[4:0] = add; bus_p.wr_data[31:0] = data;
        end else begin
            bus_p.wr_en[1] = 1'b1; bus_p.wr_add[9:5] = add; bus_p.wr_data[63:32] = data;
        end
    endtask

    task automatic rs(input int port, input logic [4:0] add);
        if (port == 0) begin
            bus_p.rs_en[0] = 1'b1; bus_p.rs_add[4:0] = add;
        end else begin
            bus_p.rs_en[1] = 1'b1; bus_p.rs_add[9:5] = add;
        end
    endtask

    task automatic rd(input logic [4:0] add);
        bus_p.rd_en  = 1'b1;
        bus_p.rd_add = add;
    endtask

    initial begin
        total = 0; bad = 0; vec_no = 0; done = 1'b0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset contents, waits and tags.
        vec(); rs(0, 5'd2); rs(1, 5'd5);
        want2(S_RS_DATA, 0, SP_INIT); want2(S_RS_DATA, 1, 32'h0);
        want2(S_RS_WAIT, 0, 0); want2(S_RS_WAIT, 1, 0);
        want2(S_RS_TAG, 0, 0); want2(S_RS_TAG, 1, 0); want2(S_RD_WAIT, 0, 0);

        // Issue x5, then a pending read waits until the writeback bypasses it.
        vec(); rd(5'd5);
        want2(S_RD_WAIT, 0, 0); want2(S_RD_TAG, 0, 0);
        vec(); rs(0, 5'd5);
        want2(S_RS_WAIT, 0, 1); want2(S_RS_TAG, 0, 1); want2(S_RS_DATA, 0, 32'h0);
        vec(); rs(0, 5'd5); wr(0, 5'd5, 32'hA5A5);
        want2(S_RS_WAIT, 0, 0); want2(S_RS_DATA, 0, 32'hA5A5);

        // Same-address writes: port 1 wins; x5 counter has drained.
        vec(); rs(0, 5'd5); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rs(1, 5'd7);
        want2(S_RS_WAIT, 0, 0); want2(S_RS_DATA, 0, 32'hA5A5); want2(S_RS_DATA, 1, 32'h22);

        // x0: write ignored, reads zero, issue does nothing.
        vec(); rs(0, 5'd7); wr(0, 5'd0, 32'hDEAD); rs(1, 5'd0); rd(5'd0);
        want2(S_RS_DATA, 0, 32'h22); want2(S_RS_DATA, 1, 32'h0); want2(S_RS_WAIT, 1, 0);
        want2(S_RD_WAIT, 0, 0); want2(S_RD_TAG, 0, 0);
        vec(); rs(0, 5'd0); rd(5'd6);
        want2(S_RS_DATA, 0, 32'h0); want2(S_RS_TAG, 0, 0);
        want2(S_RD_WAIT, 0, 0); want2(S_RD_TAG, 0, 0);

        // Second issue to x6: strict blocks, permissive accepts.
        vec(); rd(5'd6);
        want(D_STRICT, S_RD_WAIT, 0, 1); want(D_STRICT, S_RD_TAG, 0, 1);
        want(D_PERM, S_RD_WAIT, 0, 0); want(D_PERM, S_RD_TAG, 0, 1);

        // A same-cycle release lets strict issue; permissive still has one write outstanding.
        vec(); rd(5'd6); wr(1, 5'd6, 32'h66); rs(0, 5'd6);
        want(D_STRICT, S_RD_WAIT, 0, 0); want(D_STRICT, S_RD_TAG, 0, 1);
        want(D_STRICT, S_RS_WAIT, 0, 0); want(D_STRICT, S_RS_DATA, 0, 32'h66);
        want(D_PERM, S_RD_WAIT, 0, 0); want(D_PERM, S_RD_TAG, 0, 2);
        want(D_PERM, S_RS_WAIT, 0, 1); want(D_PERM, S_RS_DATA, 0, 32'h66);

        // Async reset between edges wipes memory, counters and tags.
        vec(); reset = 1'b1; rs(0, 5'd6); rs(1, 5'd7); rd(5'd6);
        want2(S_RS_DATA, 0, 32'h0); want2(S_RS_DATA, 1, 32'h0); want2(S_RS_WAIT, 0, 0);
        want2(S_RS_TAG, 0, 0); want2(S_RD_TAG, 0, 0); want2(S_RD_WAIT, 0, 0);

        // Permissive bank only from here: fill x9 to saturation.
        for (int k = 0; k < 7; k++) begin
            vec(); reset = 1'b0; rd(5'd9);
            want(D_PERM, S_RD_WAIT, 0, 0); want(D_PERM, S_RD_TAG, 0, k % 4);
        end
        vec(); rd(5'd9);
        want(D_PERM, S_RD_WAIT, 0, 1); want(D_PERM, S_RD_TAG, 0, 3);
        vec(); rd(5'd9); wr(0, 5'd9, 32'h99); rs(0, 5'd9);
        want(D_PERM, S_RD_WAIT, 0, 0); want(D_PERM, S_RD_TAG, 0, 3);
        want(D_PERM, S_RS_WAIT, 0, 1); want(D_PERM, S_RS_DATA, 0, 32'h99);
        vec(); rd(5'd9); rs(0, 5'd9);
        want(D_PERM, S_RD_WAIT, 0, 1); want(D_PERM, S_RD_TAG, 0, 0);
        want(D_PERM, S_RS_WAIT, 0, 1); want(D_PERM, S_RS_DATA, 0, 32'h99);

        // clear_de beats a same-cycle issue on the counter, but the tag still advances.
        vec(); rd(5'd3);
        want(D_PERM, S_RD_WAIT, 0, 0); want(D_PERM, S_RD_TAG, 0, 0);
        vec(); rd(5'd3);
        want(D_PERM, S_RD_WAIT, 0, 0); want(D_PERM, S_RD_TAG, 0, 1);
        vec(); rd(5'd3); bus_p.clear_de = 1'b1; rs(0, 5'd3); rs(1, 5'd9);
        want(D_PERM, S_RD_WAIT, 0, 0); want(D_PERM, S_RD_TAG, 0, 2);
        want(D_PERM, S_RS_WAIT, 0, 1); want(D_PERM, S_RS_WAIT, 1, 1);
        want(D_PERM, S_RS_DATA, 1, 32'h99);
        vec(); rs(0, 5'd3); rs(1, 5'd9);
        want(D_PERM, S_RS_WAIT, 0, 0); want(D_PERM, S_RS_TAG, 0, 3);
        want(D_PERM, S_RS_WAIT, 1, 0); want(D_PERM, S_RS_DATA, 1, 32'h99);
        want(D_PERM, S_RS_TAG, 1, 0);

        // Tag wrap on x4, then async reset mid-sequence.
        for (int k = 0; k < 5; k++) begin
            vec(); rd(5'd4);
            want(D_PERM, S_RD_WAIT, 0, 0); want(D_PERM, S_RD_TAG, 0, k % 4);
        end
        vec(); rs(0, 5'd4);
        want(D_PERM, S_RS_WAIT, 0, 1); want(D_PERM, S_RS_TAG, 0, 1);
        vec(); reset = 1'b1; rs(0, 5'd4); rs(1, 5'd2); rd(5'd4);
        want(D_PERM, S_RS_WAIT, 0, 0); want(D_PERM, S_RS_TAG, 0, 0);
        want(D_PERM, S_RD_TAG, 0, 0); want(D_PERM, S_RD_WAIT, 0, 0);
        want(D_PERM, S_RS_DATA, 1, SP_INIT);
        vec(); reset = 1'b0; rs(0, 5'd9);
        want(D_PERM, S_RS_DATA, 0, 32'h0); want(D_PERM, S_RS_WAIT, 0, 0);

        @(posedge clk);
        #1;
        idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked expectations want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        done = 1'b1;
        $finish;
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: got no completion want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
